elevator_call_dispatcher: RTL and testbench
===========================================

Name: elevator_call_dispatcher

Overview:
- Upstream request stage for the 3-floor elevator controller.
- Synchronises and debounces the raw floor call buttons, then latches them as pending calls.
- Picks one target floor at a time using a direction-preserving (SCAN) policy and offers it downstream as a one-hot floor request over a valid/ready handshake.
- Clears a call only when the downstream stage reports arrival.

Parameters:
- DB_CYCLES, 4: consecutive stable synchronised samples required to accept a level change on a button.
- DB_W, 3: width of each per-button debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, asynchronous, active-high; clock clk.
- btn_raw, input, 3: raw asynchronous call buttons; bit0 = floor 1, bit1 = floor 2, bit2 = floor 3.
- cur_floor, input, 2: current car position from downstream; 1..3, where 0 = unknown and is treated as floor 1.
- arrived, input, 1: single-cycle pulse from downstream when the car reaches the accepted target.
- req_valid, output, 1: floor request offered.
- req_floor, output, 3: one-hot target floor, same bit order as btn_raw.
- req_ready, input, 1: downstream accepts the request.
- pending, output, 3: latched outstanding calls.
- dir_up, output, 1: current sweep direction; 1 = up.
- busy, output, 1: a request has been accepted and arrival is awaited.

Behaviour:
- Reset values: req_valid=0, req_floor=000, pending=000, dir_up=1, busy=0, FSM=IDLE, all sync flops and debounce counters 0. Reset asserted mid-operation aborts any offer or trip immediately; nothing is retained.
- Input path: 2-flop synchroniser per button, then a debouncer.
  - The debounced level toggles only after DB_CYCLES consecutive synchronised samples differ from it; any agreeing sample zeroes the counter.
  - A debounced 0->1 edge produces a one-cycle press event.
  - A held button produces exactly one event and must be released (debounced) before it can produce another.
- Pending register: bit n is set on a press event for floor n, and cleared on arrived while busy=1 for the accepted target bit. If a set and a clear hit the same bit in the same cycle, the clear wins. Presses for floors already pending are ignored.
- Press-to-pending latency: 2 + DB_CYCLES cycles from the raw edge to pending visible, given a clean input.
- Target selection (combinational from pending, cur_floor, dir_up; evaluated only in IDLE), in priority order:
  - (a) pending bit at cur_floor;
  - (b) the nearest pending floor strictly in the dir_up direction;
  - (c) the nearest pending floor in the opposite direction. Choosing (c) toggles dir_up on the IDLE->OFFER transition.
  - At floor 3 with dir_up=1, or floor 1 with dir_up=0, no floor exists in direction (b), so the choice falls to (c).
- FSM:
  - IDLE: if pending!=0, register the selected target into req_floor, set req_valid=1, go to OFFER (req_valid high 1 cycle after pending is nonzero). Otherwise stay.
  - OFFER: hold req_valid=1 with req_floor frozen; new presses only update pending. On req_valid&&req_ready: req_valid=0, busy=1, go to BUSY. No retargeting while in OFFER.
  - BUSY: req_floor held; wait for arrived. On arrived: clear the target pending bit, busy=0, go to IDLE. The next target is offered no earlier than the following cycle.
- Handshake rules:
  - req_valid never drops without acceptance except on reset.
  - req_floor is always one-hot while req_valid=1.
  - arrived while not in BUSY is ignored.
  - req_ready while req_valid=0 is ignored.
- Simultaneous presses on several floors are all latched in the same cycle; selection then follows the priority order above.

Test Plan:
- Reset sequence: assert reset mid-BUSY with pending=101 -> all outputs read their reset values on the same edge; after release nothing is offered until a new press.
- Debounce check, DB_CYCLES=4: btn_raw[1] glitches high for 3 cycles -> pending stays 000. Held high 10 cycles -> pending=010 exactly 6 cycles after the rising edge, and one event only.
- Handshake with cur_floor=1: pending=010, req_ready held 0 for 5 cycles -> req_valid=1 and req_floor=010 stable throughout. req_ready=1 -> busy=1 next cycle; arrived pulse -> pending=000, busy=0.
- SCAN ordering: cur_floor=2, dir_up=1, pending=101 -> first offer 100 with dir_up staying 1. After arrival with cur_floor=3 -> next offer 001 and dir_up=0.
- Same-floor call: cur_floor=3, pending=100 in IDLE -> offer 100 via rule (a), dir_up unchanged.
- Collision: a press for floor 2 lands in the same cycle as arrived for target 010 -> pending bit1 ends 0. A later release and re-press sets it again.

Source files
------------

// File: rtl/elevator_call_dispatcher.sv
// Debounces 3 floor call buttons, latches pending calls, and offers one SCAN-selected target at a time.
// Press-to-pending 2+DB_CYCLES cycles; offer 1 cycle after pending; request held until req_ready.
module elevator_call_dispatcher #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn_raw,
  input  logic [1:0] cur_floor,
  input  logic       arrived,
  output logic       req_valid,
  output logic [2:0] req_floor,
  input  logic       req_ready,
  output logic [2:0] pending,
  output logic       dir_up,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] sync1, sync2, db_level, press;
  logic [2:0] sel, clr;
  logic       sel_flip, load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic            lvl;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        lvl <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign db_level[i] = lvl;
    // Press fires on the same edge the debounced level rises.
    assign press[i]    = sync2[i] & ~lvl & (cnt == DB_LAST);
  end

  // SCAN target: current floor, then nearest ahead, then nearest behind (flipping direction).
  always_comb begin
    logic [1:0] cf_idx;
    logic [2:0] up_vec, dn_vec;
    sel      = 3'b000;
    sel_flip = 1'b0;
    up_vec   = 3'b000;
    dn_vec   = 3'b000;
    cf_idx   = (cur_floor == 2'd0) ? 2'd0 : cur_floor - 2'd1;
    for (int j = 2; j >= 0; j--) begin
      if (j > int'(cf_idx) && pending[j]) up_vec = 3'b001 << j;
    end
    for (int j = 0; j < 3; j++) begin
      if (j < int'(cf_idx) && pending[j]) dn_vec = 3'b001 << j;
    end
    if (pending[cf_idx]) begin
      sel[cf_idx] = 1'b1;
    end else if (dir_up) begin
      if (|up_vec) begin
        sel = up_vec;
      end else begin
        sel      = dn_vec;
        sel_flip = 1'b1;
      end
    end else begin
      if (|dn_vec) begin
        sel = dn_vec;
      end else begin
        sel      = up_vec;
        sel_flip = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pending) state_nxt = OFFER;
      OFFER:   if (req_ready) state_nxt = BUSY;
      BUSY:    if (arrived) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_valid = (state == OFFER);
    busy      = (state == BUSY);
    load      = (state == IDLE) && (|pending);
    clr       = (busy && arrived) ? req_floor : 3'b000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_floor <= 3'b000;
      dir_up    <= 1'b1;
      pending   <= 3'b000;
    end else begin
      pending <= (pending | press) & ~clr;
      if (load) begin
        req_floor <= sel;
        if (sel_flip) dir_up <= ~dir_up;
      end
    end
  end

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed bench for elevator_call_dispatcher: debounce, handshake, SCAN order, collision and reset.
module tb_elevator_call_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_raw;
  logic [1:0] cur_floor;
  logic       arrived;
  logic       req_valid;
  logic [2:0] req_floor;
  logic       req_ready;
  logic [2:0] pending;
  logic       dir_up;
  logic       busy;

  int checks = 0;
  int errors = 0;

  elevator_call_dispatcher #(.DB_CYCLES(4), .DB_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .cur_floor (cur_floor),
    .arrived   (arrived),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .req_ready (req_ready),
    .pending   (pending),
    .dir_up    (dir_up),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] mask);
    btn_raw = mask;
    repeat (8) tick();
    btn_raw = 3'b000;
    repeat (8) tick();
  endtask

  task automatic accept();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic arrive();
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    btn_raw   = 3'b000;
    cur_floor = 2'd1;
    arrived   = 1'b0;
    req_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid",   32'(req_valid), 32'd0);
    check("rst_floor",   32'(req_floor), 32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_dir",     32'(dir_up),    32'd1);
    check("rst_busy",    32'(busy),      32'd0);
    reset = 1'b0;
    tick();

    // 3-cycle glitch must not register
    btn_raw = 3'b010;
    repeat (3) tick();
    btn_raw = 3'b000;
    repeat (10) tick();
    check("glitch_pending", 32'(pending),   32'd0);
    check("glitch_valid",   32'(req_valid), 32'd0);

    // Held press: visible exactly 6 cycles after the raw edge
    btn_raw = 3'b010;
    repeat (5) tick();
    check("pend_t5", 32'(pending), 32'b000);
    tick();
    check("pend_t6",  32'(pending),   32'b010);
    check("valid_t6", 32'(req_valid), 32'd0);
    tick();
    check("valid_t7", 32'(req_valid), 32'd1);
    check("floor_t7", 32'(req_floor), 32'b010);
    repeat (3) tick();
    btn_raw = 3'b000;
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 32'(req_valid), 32'd1);
      check("hold_floor", 32'(req_floor), 32'b010);
      tick();
    end
    arrive();
    check("early_arr_pending", 32'(pending),   32'b010);
    check("early_arr_valid",   32'(req_valid), 32'd1);
    accept();
    check("acc_busy",  32'(busy),      32'd1);
    check("acc_valid", 32'(req_valid), 32'd0);
    arrive();
    check("arr_pending", 32'(pending), 32'b000);
    check("arr_busy",    32'(busy),    32'd0);
    repeat (20) tick();
    check("one_event_pending", 32'(pending),   32'b000);
    check("one_event_valid",   32'(req_valid), 32'd0);

    // SCAN: floor 2 going up with calls at 1 and 3
    cur_floor = 2'd2;
    press(3'b101);
    check("scan1_pending", 32'(pending),   32'b101);
    check("scan1_valid",   32'(req_valid), 32'd1);
    check("scan1_floor",   32'(req_floor), 32'b100);
    check("scan1_dir",     32'(dir_up),    32'd1);
    accept();
    cur_floor = 2'd3;
    arrive();
    check("scan_arr_pending", 32'(pending),   32'b001);
    check("scan_arr_valid",   32'(req_valid), 32'd0);
    tick();
    check("scan2_valid", 32'(req_valid), 32'd1);
    check("scan2_floor", 32'(req_floor), 32'b001);
    check("scan2_dir",   32'(dir_up),    32'd0);
    accept();
    cur_floor = 2'd1;
    arrive();
    check("scan_done_pending", 32'(pending), 32'b000);

    // Same-floor call keeps direction
    cur_floor = 2'd3;
    press(3'b100);
    check("same_floor", 32'(req_floor), 32'b100);
    check("same_dir",   32'(dir_up),    32'd0);
    accept();
    arrive();
    check("same_done", 32'(pending), 32'b000);

    // Collision: press event on the arrival cycle for the same floor
    cur_floor = 2'd1;
    press(3'b010);
    check("col_offer", 32'(req_floor), 32'b010);
    accept();
    btn_raw = 3'b010;
    repeat (5) tick();
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
    check("collide_pending", 32'(pending), 32'b000);
    check("collide_busy",    32'(busy),    32'd0);
    repeat (4) tick();
    btn_raw = 3'b000;
    repeat (10) tick();
    check("collide_held", 32'(pending), 32'b000);
    press(3'b010);
    check("repress_pending", 32'(pending),   32'b010);
    check("repress_valid",   32'(req_valid), 32'd1);
    accept();
    arrive();

    // Reset mid-BUSY with pending=101
    cur_floor = 2'd1;
    press(3'b101);
    check("pre_rst_floor", 32'(req_floor), 32'b001);
    accept();
    check("pre_rst_busy",    32'(busy),    32'd1);
    check("pre_rst_pending", 32'(pending), 32'b101);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid",   32'(req_valid), 32'd0);
    check("mid_rst_floor",   32'(req_floor), 32'd0);
    check("mid_rst_pending", 32'(pending),   32'd0);
    check("mid_rst_dir",     32'(dir_up),    32'd1);
    check("mid_rst_busy",    32'(busy),      32'd0);
    tick();
    #2 reset = 1'b0;
    repeat (10) tick();
    check("post_rst_valid",   32'(req_valid), 32'd0);
    check("post_rst_pending", 32'(pending),   32'd0);
    check("post_rst_busy",    32'(busy),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
